// File: rtl/dkong3_mmio_pkg.sv
// Shared decode constants, slot map and wait-FSM encoding for the main-CPU MMIO block.
package dkong3_mmio_pkg;

   // Address windows (upper address bits)
   localparam logic [5:0] IO_WIN_TAG   = 6'b011111;   // 7C00-7FFF
   localparam logic [4:0] VRAM_WIN_TAG = 5'b01110;    // 7000-77FF

   // Write/read slot numbers inside the IO window (I_AB[9:7])
   localparam logic [2:0] SLOT_SND0   = 3'd0;
   localparam logic [2:0] SLOT_SND1   = 3'd1;
   localparam logic [2:0] SLOT_SND2   = 3'd2;
   localparam logic [2:0] SLOT_SND3   = 3'd3;
   localparam logic [2:0] SLOT_SUBRST = 3'd4;
   localparam logic [2:0] SLOT_BANK0  = 3'd5;

   // Bank 0 bit that gates the VBLANK NMI
   localparam int NMI_EN_BIT = 4;

   // VRAM wait-state controller states
   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_WAIT = 2'd1,
      W_HOLD = 2'd2
   } wait_state_t;

   // One-hot decode of a 3-bit latch address
   function automatic logic [7:0] bit_onehot(input logic [2:0] addr);
      return 8'b0000_0001 << addr;
   endfunction

endpackage

// File: rtl/dkong3_addr_latch.sv
// Generic 8-bit addressable latch (259-style): one selected bit loads I_D when I_EN is high.
module dkong3_addr_latch
   import dkong3_mmio_pkg::*;
(
   input  logic       I_CLK,
   input  logic       I_RESET,
   input  logic       I_EN,
   input  logic [2:0] I_ADDR,
   input  logic       I_D,
   output logic [7:0] O_Q
);

   logic [7:0] sel;

   assign sel = bit_onehot(I_ADDR) & {8{I_EN}};

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bit
         logic q_reg;

         // Each bit holds its value until it is the addressed bit of an enabled write
         always_ff @(posedge I_CLK) begin
            if (I_RESET)
               q_reg <= 1'b0;
            else if (sel[gi])
               q_reg <= I_D;
         end

         assign O_Q[gi] = q_reg;
      end
   endgenerate

endmodule

// File: rtl/dkong3_mmio_ctrl.sv
// Main-CPU memory-mapped control: VRAM wait FSM, VBLANK NMI latch, addressable
// latch banks, one-shot sound strobes and sub-CPU reset register.
module dkong3_mmio_ctrl
   import dkong3_mmio_pkg::*;
#(
   parameter int NUM_BANKS = 1,
   parameter int NUM_SUB   = 2,
   parameter int WAIT_MAX  = 15
) (
   input  logic                   I_CLK,
   input  logic                   I_RESET,
   input  logic [15:0]            I_AB,
   input  logic [7:0]             I_DB,
   input  logic                   I_MREQ_n,
   input  logic                   I_RFSH_n,
   input  logic                   I_RD_n,
   input  logic                   I_WR_n,
   input  logic                   I_VRAMBUSY_n,
   input  logic                   I_VBLK_n,
   output logic                   O_WAIT_n,
   output logic                   O_WAIT_TO,
   output logic                   O_NMI_n,
   output logic [3:0]             O_IN_OE_n,
   output logic [3:0]             O_SND_STB,
   output logic [8*NUM_BANKS-1:0] O_LATCH,
   output logic [NUM_SUB-1:0]     O_SUB_RESET_n
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(WAIT_MAX - 1);

   // ---------------- address decode ----------------
   logic       io_win;
   logic       vram_win;
   logic [2:0] slot;
   logic [2:0] bit_addr;
   logic       unused_bus;

   assign io_win     = (I_AB[15:10] == IO_WIN_TAG);
   assign vram_win   = (I_AB[15:11] == VRAM_WIN_TAG);
   assign slot       = I_AB[9:7];
   assign bit_addr   = I_AB[2:0];
   assign unused_bus = ^{I_DB[7:1], I_AB[6:3]};

   // Read strobes are pure decode so input buffers open within the bus cycle
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_rd
         assign O_IN_OE_n[gi] = ~(io_win && (slot == 3'(gi)) && !I_RD_n && !I_MREQ_n);
      end
   endgenerate

   // ---------------- write strobe ----------------
   logic wr_act;
   logic wr_q_reg;
   logic wstb;

   assign wr_act = io_win && !I_WR_n && !I_MREQ_n;
   assign wstb   = wr_act && !wr_q_reg;

   // Previous-cycle write activity; resets high so a write straddling reset is dropped
   always_ff @(posedge I_CLK) begin
      if (I_RESET)
         wr_q_reg <= 1'b1;
      else
         wr_q_reg <= wr_act;
   end

   // ---------------- sound strobes ----------------
   logic [3:0] snd_stb_next;
   logic [3:0] snd_stb_reg;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_snd
         assign snd_stb_next[gi] = wstb && (slot == 3'(gi));
      end
   endgenerate

   // One-cycle pulse per bus write to slots 0..3
   always_ff @(posedge I_CLK) begin
      if (I_RESET)
         snd_stb_reg <= '0;
      else
         snd_stb_reg <= snd_stb_next;
   end

   assign O_SND_STB = snd_stb_reg;

   // ---------------- sub-CPU resets ----------------
   logic [NUM_SUB-1:0] sub_sel;
   logic [NUM_SUB-1:0] sub_rst_reg;

   generate
      for (genvar gi = 0; gi < NUM_SUB; gi++) begin : g_sub
         assign sub_sel[gi] = wstb && (slot == SLOT_SUBRST) && (bit_addr == 3'(gi));
      end
   endgenerate

   // Addressed channel takes D0; bit addresses beyond NUM_SUB never select anything
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         sub_rst_reg <= '0;
      end else begin
         for (int i = 0; i < NUM_SUB; i++) begin
            if (sub_sel[i])
               sub_rst_reg[i] <= I_DB[0];
         end
      end
   end

   assign O_SUB_RESET_n = sub_rst_reg;

   // ---------------- latch banks ----------------
   logic [8*NUM_BANKS-1:0] latch_q;

   generate
      for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
         logic bank_en;

         assign bank_en = wstb && (slot == (SLOT_BANK0 + 3'(gi)));

         dkong3_addr_latch u_latch (
            .I_CLK   (I_CLK),
            .I_RESET (I_RESET),
            .I_EN    (bank_en),
            .I_ADDR  (bit_addr),
            .I_D     (I_DB[0]),
            .O_Q     (latch_q[8*gi +: 8])
         );
      end
   endgenerate

   assign O_LATCH = latch_q;

   // ---------------- VBLANK NMI ----------------
   logic nmi_en;
   logic en_clear;
   logic vblk_q_reg;
   logic vblank_start;
   logic nmi_pend_reg;
   logic nmi_pend_next;

   assign nmi_en       = latch_q[NMI_EN_BIT];
   // A write dropping the enable this cycle must beat a coincident VBLANK edge
   assign en_clear     = wstb && (slot == SLOT_BANK0) && (bit_addr == 3'(NMI_EN_BIT)) && !I_DB[0];
   assign vblank_start = vblk_q_reg && !I_VBLK_n;

   // Pending NMI: set on VBLANK start while enabled, held until the enable is cleared
   always_comb begin
      nmi_pend_next = nmi_pend_reg;
      if (!nmi_en || en_clear)
         nmi_pend_next = 1'b0;
      else if (vblank_start)
         nmi_pend_next = 1'b1;
   end

   // VBLANK edge history and NMI pending flag
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         vblk_q_reg   <= 1'b1;
         nmi_pend_reg <= 1'b0;
      end else begin
         vblk_q_reg   <= I_VBLK_n;
         nmi_pend_reg <= nmi_pend_next;
      end
   end

   assign O_NMI_n = ~nmi_pend_reg;

   // ---------------- VRAM wait FSM ----------------
   wait_state_t state_reg;
   wait_state_t state_next;
   logic [7:0]  cnt_reg;
   logic [7:0]  cnt_next;
   logic        wait_to_reg;
   logic        wait_to_next;

   // Stretch VRAM accesses while video owns the bus; HOLD blocks re-waiting the same access
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      wait_to_next = wait_to_reg;
      case (state_reg)
         W_IDLE: begin
            if (vram_win && !I_MREQ_n && I_RFSH_n && !I_VRAMBUSY_n) begin
               state_next = W_WAIT;
               cnt_next   = 8'd0;
            end
         end
         W_WAIT: begin
            cnt_next = cnt_reg + 8'd1;
            if (I_VRAMBUSY_n || !I_VBLK_n) begin
               state_next = W_HOLD;
            end else if (cnt_reg == TIMEOUT_CNT) begin
               state_next   = W_HOLD;
               wait_to_next = 1'b1;
            end
         end
         W_HOLD: begin
            if (I_MREQ_n)
               state_next = W_IDLE;
         end
         default: state_next = W_IDLE;
      endcase
   end

   // Wait FSM state, cycle counter and sticky timeout flag
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         state_reg   <= W_IDLE;
         cnt_reg     <= 8'd0;
         wait_to_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         wait_to_reg <= wait_to_next;
      end
   end

   assign O_WAIT_n  = (state_reg != W_WAIT);
   assign O_WAIT_TO = wait_to_reg;

endmodule

// File: tb/tb_dkong3_mmio_ctrl.sv
// Directed self-checking bench for dkong3_mmio_ctrl (default parameters).
module tb_dkong3_mmio_ctrl;

   logic        I_CLK;
   logic        I_RESET;
   logic [15:0] I_AB;
   logic [7:0]  I_DB;
   logic        I_MREQ_n;
   logic        I_RFSH_n;
   logic        I_RD_n;
   logic        I_WR_n;
   logic        I_VRAMBUSY_n;
   logic        I_VBLK_n;
   logic        O_WAIT_n;
   logic        O_WAIT_TO;
   logic        O_NMI_n;
   logic [3:0]  O_IN_OE_n;
   logic [3:0]  O_SND_STB;
   logic [7:0]  O_LATCH;
   logic [1:0]  O_SUB_RESET_n;

   int tests_run = 0;
   int fails     = 0;

   dkong3_mmio_ctrl #(.NUM_BANKS(1), .NUM_SUB(2), .WAIT_MAX(15)) dut (
      .I_CLK         (I_CLK),
      .I_RESET       (I_RESET),
      .I_AB          (I_AB),
      .I_DB          (I_DB),
      .I_MREQ_n      (I_MREQ_n),
      .I_RFSH_n      (I_RFSH_n),
      .I_RD_n        (I_RD_n),
      .I_WR_n        (I_WR_n),
      .I_VRAMBUSY_n  (I_VRAMBUSY_n),
      .I_VBLK_n      (I_VBLK_n),
      .O_WAIT_n      (O_WAIT_n),
      .O_WAIT_TO     (O_WAIT_TO),
      .O_NMI_n       (O_NMI_n),
      .O_IN_OE_n     (O_IN_OE_n),
      .O_SND_STB     (O_SND_STB),
      .O_LATCH       (O_LATCH),
      .O_SUB_RESET_n (O_SUB_RESET_n)
   );

   initial I_CLK = 1'b0;
   always #5 I_CLK = ~I_CLK;

   // Read-decode vectors: address and the expected active-low strobe pattern
   logic [15:0] rd_addr [7] = '{16'h7C00, 16'h7C80, 16'h7D00, 16'h7D80, 16'h7E00, 16'h7800, 16'h7C05};
   logic [3:0]  rd_exp  [7] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hF, 4'hF, 4'hE};
   logic [3:0]  snd_exp [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

   task automatic tick();
      @(posedge I_CLK);
      #1;
   endtask

   task automatic bus_idle();
      I_AB     = 16'h0000;
      I_MREQ_n = 1'b1;
      I_RD_n   = 1'b1;
      I_WR_n   = 1'b1;
   endtask

   task automatic wr_start(input logic [15:0] a, input logic [7:0] d);
      I_AB     = a;
      I_DB     = d;
      I_MREQ_n = 1'b0;
      I_WR_n   = 1'b0;
   endtask

   // Two-cycle bus write followed by one idle cycle; effect is visible on return
   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      wr_start(a, d);
      tick();
      tick();
      bus_idle();
      tick();
      $display("[TB] write %h <= %h : latch=%h sub=%b nmi_n=%b", a, d, O_LATCH, O_SUB_RESET_n, O_NMI_n);
   endtask

   task automatic test_reset();
      bus_idle();
      I_DB = 8'h00; I_RFSH_n = 1'b1; I_VRAMBUSY_n = 1'b1; I_VBLK_n = 1'b1;
      I_RESET = 1'b1;
      tick();
      tick();
      I_RESET = 1'b0;
      tests_run++; if (O_WAIT_n !== 1'b1) begin fails++; $display("FAIL rst_wait_n got %b want 1", O_WAIT_n); end
      tests_run++; if (O_WAIT_TO !== 1'b0) begin fails++; $display("FAIL rst_wait_to got %b want 0", O_WAIT_TO); end
      tests_run++; if (O_NMI_n !== 1'b1) begin fails++; $display("FAIL rst_nmi_n got %b want 1", O_NMI_n); end
      tests_run++; if (O_SND_STB !== 4'h0) begin fails++; $display("FAIL rst_snd got %h want 0", O_SND_STB); end
      tests_run++; if (O_LATCH !== 8'h00) begin fails++; $display("FAIL rst_latch got %h want 00", O_LATCH); end
      tests_run++; if (O_SUB_RESET_n !== 2'b00) begin fails++; $display("FAIL rst_sub got %b want 00", O_SUB_RESET_n); end
      tests_run++; if (O_IN_OE_n !== 4'hF) begin fails++; $display("FAIL rst_in_oe got %h want F", O_IN_OE_n); end
      $display("[TB] reset: wait_n=%b to=%b nmi_n=%b latch=%h sub=%b", O_WAIT_n, O_WAIT_TO, O_NMI_n, O_LATCH, O_SUB_RESET_n);
   endtask

   task automatic test_read_decode();
      for (int i = 0; i < 7; i++) begin
         I_AB = rd_addr[i]; I_MREQ_n = 1'b0; I_RD_n = 1'b0;
         #1;
         tests_run++;
         if (O_IN_OE_n !== rd_exp[i]) begin fails++; $display("FAIL rd_decode addr=%h got %h want %h", rd_addr[i], O_IN_OE_n, rd_exp[i]); end
         $display("[TB] read %h : in_oe_n=%h", rd_addr[i], O_IN_OE_n);
      end
      I_AB = 16'h7C00; I_MREQ_n = 1'b1;
      #1;
      tests_run++; if (O_IN_OE_n !== 4'hF) begin fails++; $display("FAIL rd_no_mreq got %h want F", O_IN_OE_n); end
      bus_idle();
      tick();
   endtask

   task automatic test_snd_strobes();
      int cnt;
      logic [3:0] seen;
      for (int s = 0; s < 4; s++) begin
         cnt = 0; seen = 4'h0;
         wr_start(16'h7C00 + 16'(s * 128), 8'h00);
         for (int k = 0; k < 6; k++) begin
            tick();
            if (O_SND_STB !== 4'h0) begin cnt++; seen = seen | O_SND_STB; end
         end
         bus_idle();
         tick();
         if (O_SND_STB !== 4'h0) cnt++;
         tests_run++; if (cnt != 1) begin fails++; $display("FAIL snd_count slot%0d got %0d want 1", s, cnt); end
         tests_run++; if (seen !== snd_exp[s]) begin fails++; $display("FAIL snd_value slot%0d got %h want %h", s, seen, snd_exp[s]); end
         $display("[TB] snd slot%0d held 6 cycles: pulses=%0d value=%h", s, cnt, seen);
      end
   endtask

   task automatic test_latch_write();
      wr_start(16'h7E84, 8'h01);
      #1;
      tests_run++; if (O_LATCH !== 8'h00) begin fails++; $display("FAIL latch_before got %h want 00", O_LATCH); end
      tick();
      tests_run++; if (O_LATCH !== 8'h10) begin fails++; $display("FAIL latch_set got %h want 10", O_LATCH); end
      for (int k = 0; k < 5; k++) tick();
      bus_idle();
      tick();
      tests_run++; if (O_LATCH !== 8'h10) begin fails++; $display("FAIL latch_hold got %h want 10", O_LATCH); end
      $display("[TB] latch 7E84 <= 1 held 6 cycles: latch=%h", O_LATCH);
      bus_write(16'h7F00, 8'h01);
      bus_write(16'h7F81, 8'h01);
      tests_run++; if (O_LATCH !== 8'h10) begin fails++; $display("FAIL latch_ignored_slots got %h want 10", O_LATCH); end
      tests_run++; if (O_SUB_RESET_n !== 2'b00) begin fails++; $display("FAIL sub_ignored_slots got %b want 00", O_SUB_RESET_n); end
   endtask

   task automatic test_sub_reset();
      bus_write(16'h7E00, 8'h01);
      tests_run++; if (O_SUB_RESET_n !== 2'b01) begin fails++; $display("FAIL sub_bit0 got %b want 01", O_SUB_RESET_n); end
      bus_write(16'h7E01, 8'h01);
      tests_run++; if (O_SUB_RESET_n !== 2'b11) begin fails++; $display("FAIL sub_bit1 got %b want 11", O_SUB_RESET_n); end
      bus_write(16'h7E05, 8'h00);
      tests_run++; if (O_SUB_RESET_n !== 2'b11) begin fails++; $display("FAIL sub_bit5 got %b want 11", O_SUB_RESET_n); end
      bus_write(16'h7E00, 8'h00);
      tests_run++; if (O_SUB_RESET_n !== 2'b10) begin fails++; $display("FAIL sub_clr0 got %b want 10", O_SUB_RESET_n); end
      tests_run++; if (O_LATCH !== 8'h10) begin fails++; $display("FAIL sub_latch_untouched got %h want 10", O_LATCH); end
   endtask

   task automatic test_wait_short();
      int low;
      int first;
      low = 0; first = -1;
      I_AB = 16'h7400; I_MREQ_n = 1'b0; I_RD_n = 1'b0; I_VRAMBUSY_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (O_WAIT_n === 1'b0) begin low++; if (first < 0) first = i; end
         if (i == 4) I_VRAMBUSY_n = 1'b1;
         if (i == 7) I_VRAMBUSY_n = 1'b0;
      end
      tests_run++; if (low != 5) begin fails++; $display("FAIL wait_short_len got %0d want 5", low); end
      tests_run++; if (first != 0) begin fails++; $display("FAIL wait_short_start got %0d want 0", first); end
      tests_run++; if (O_WAIT_TO !== 1'b0) begin fails++; $display("FAIL wait_short_to got %b want 0", O_WAIT_TO); end
      bus_idle();
      tick();
      tests_run++; if (O_WAIT_n !== 1'b1) begin fails++; $display("FAIL wait_idle_no_mreq got %b want 1", O_WAIT_n); end
      I_VRAMBUSY_n = 1'b1;
      tick();
      $display("[TB] wait busy 5 cycles: low=%0d first=%0d to=%b", low, first, O_WAIT_TO);
   endtask

   task automatic test_wait_qualifiers();
      int low;
      low = 0;
      I_AB = 16'h7400; I_MREQ_n = 1'b0; I_RFSH_n = 1'b0; I_VRAMBUSY_n = 1'b0;
      for (int i = 0; i < 4; i++) begin tick(); if (O_WAIT_n === 1'b0) low++; end
      bus_idle(); I_RFSH_n = 1'b1; tick();
      I_AB = 16'h7800; I_MREQ_n = 1'b0;
      for (int i = 0; i < 4; i++) begin tick(); if (O_WAIT_n === 1'b0) low++; end
      tests_run++; if (low != 0) begin fails++; $display("FAIL wait_qualifiers got %0d low cycles want 0", low); end
      bus_idle(); tick();
      low = 0;
      I_AB = 16'h7400; I_MREQ_n = 1'b0; I_VBLK_n = 1'b0;
      for (int i = 0; i < 6; i++) begin tick(); if (O_WAIT_n === 1'b0) low++; end
      tests_run++; if (low != 1) begin fails++; $display("FAIL wait_vblank_len got %0d want 1", low); end
      tests_run++; if (O_WAIT_TO !== 1'b0) begin fails++; $display("FAIL wait_vblank_to got %b want 0", O_WAIT_TO); end
      bus_idle(); I_VBLK_n = 1'b1; I_VRAMBUSY_n = 1'b1; tick();
      $display("[TB] wait vblank release: low=%0d to=%b", low, O_WAIT_TO);
   endtask

   task automatic test_wait_timeout();
      int low;
      low = 0;
      I_AB = 16'h7400; I_MREQ_n = 1'b0; I_RD_n = 1'b0; I_VRAMBUSY_n = 1'b0;
      for (int i = 0; i < 40; i++) begin tick(); if (O_WAIT_n === 1'b0) low++; end
      tests_run++; if (low != 15) begin fails++; $display("FAIL wait_timeout_len got %0d want 15", low); end
      tests_run++; if (O_WAIT_TO !== 1'b1) begin fails++; $display("FAIL wait_timeout_flag got %b want 1", O_WAIT_TO); end
      bus_idle();
      tick();
      tests_run++; if (O_WAIT_n !== 1'b1) begin fails++; $display("FAIL wait_after_timeout got %b want 1", O_WAIT_n); end
      I_VRAMBUSY_n = 1'b1;
      tick();
      $display("[TB] wait busy 40 cycles: low=%0d to=%b", low, O_WAIT_TO);
   endtask

   task automatic test_nmi();
      bus_write(16'h7E84, 8'h00);
      tests_run++; if (O_NMI_n !== 1'b1) begin fails++; $display("FAIL nmi_disabled got %b want 1", O_NMI_n); end
      bus_write(16'h7E84, 8'h01);
      tests_run++; if (O_NMI_n !== 1'b1) begin fails++; $display("FAIL nmi_enable_only got %b want 1", O_NMI_n); end
      I_VBLK_n = 1'b0;
      tick();
      tests_run++; if (O_NMI_n !== 1'b0) begin fails++; $display("FAIL nmi_on_edge got %b want 0", O_NMI_n); end
      tick(); tick();
      I_VBLK_n = 1'b1;
      tick();
      tests_run++; if (O_NMI_n !== 1'b0) begin fails++; $display("FAIL nmi_held got %b want 0", O_NMI_n); end
      // clear write coincident with a fresh VBLANK edge
      wr_start(16'h7E84, 8'h00); I_VBLK_n = 1'b0;
      tick();
      tests_run++; if (O_NMI_n !== 1'b1) begin fails++; $display("FAIL nmi_clear_pending got %b want 1", O_NMI_n); end
      bus_idle(); I_VBLK_n = 1'b1; tick();
      bus_write(16'h7E84, 8'h01);
      wr_start(16'h7E84, 8'h00); I_VBLK_n = 1'b0;
      tick();
      tests_run++; if (O_NMI_n !== 1'b1) begin fails++; $display("FAIL nmi_clear_wins got %b want 1", O_NMI_n); end
      bus_idle(); tick();
      tests_run++; if (O_NMI_n !== 1'b1) begin fails++; $display("FAIL nmi_clear_wins_after got %b want 1", O_NMI_n); end
      I_VBLK_n = 1'b1; tick(); I_VBLK_n = 1'b0; tick();
      tests_run++; if (O_NMI_n !== 1'b1) begin fails++; $display("FAIL nmi_edge_disabled got %b want 1", O_NMI_n); end
      I_VBLK_n = 1'b1;
      bus_write(16'h7E84, 8'h01);
      I_VBLK_n = 1'b0;
      tick();
      tests_run++; if (O_NMI_n !== 1'b0) begin fails++; $display("FAIL nmi_rearm got %b want 0", O_NMI_n); end
      I_VBLK_n = 1'b1;
      tick();
      $display("[TB] nmi sequence done: nmi_n=%b latch=%h", O_NMI_n, O_LATCH);
   endtask

   task automatic test_reset_mid();
      int cnt;
      I_AB = 16'h7400; I_MREQ_n = 1'b0; I_RD_n = 1'b0; I_VRAMBUSY_n = 1'b0;
      tick(); tick();
      tests_run++; if (O_WAIT_n !== 1'b0) begin fails++; $display("FAIL mid_in_wait got %b want 0", O_WAIT_n); end
      I_RESET = 1'b1;
      tick();
      tests_run++; if (O_WAIT_n !== 1'b1) begin fails++; $display("FAIL mid_rst_wait_n got %b want 1", O_WAIT_n); end
      tests_run++; if (O_NMI_n !== 1'b1) begin fails++; $display("FAIL mid_rst_nmi_n got %b want 1", O_NMI_n); end
      tests_run++; if (O_LATCH !== 8'h00) begin fails++; $display("FAIL mid_rst_latch got %h want 00", O_LATCH); end
      tests_run++; if (O_SUB_RESET_n !== 2'b00) begin fails++; $display("FAIL mid_rst_sub got %b want 00", O_SUB_RESET_n); end
      tests_run++; if (O_WAIT_TO !== 1'b0) begin fails++; $display("FAIL mid_rst_to got %b want 0", O_WAIT_TO); end
      $display("[TB] reset mid-wait: wait_n=%b nmi_n=%b latch=%h sub=%b", O_WAIT_n, O_NMI_n, O_LATCH, O_SUB_RESET_n);
      bus_idle(); I_VRAMBUSY_n = 1'b1;
      wr_start(16'h7C00, 8'h00);
      tick();
      I_RESET = 1'b0;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin tick(); if (O_SND_STB !== 4'h0) cnt++; end
      tests_run++; if (cnt != 0) begin fails++; $display("FAIL mid_write_dropped got %0d pulses want 0", cnt); end
      bus_idle(); tick();
      wr_start(16'h7C80, 8'h00);
      tick();
      tests_run++; if (O_SND_STB !== 4'h2) begin fails++; $display("FAIL post_reset_write got %h want 2", O_SND_STB); end
      bus_idle(); tick();
      $display("[TB] reset mid-write: pulses=%0d", cnt);
   endtask

   initial begin
      I_RESET = 1'b1;
      I_DB = 8'h00; I_RFSH_n = 1'b1; I_VRAMBUSY_n = 1'b1; I_VBLK_n = 1'b1;
      bus_idle();
      test_reset();
      test_read_decode();
      test_snd_strobes();
      test_latch_write();
      test_sub_reset();
      test_wait_short();
      test_wait_qualifiers();
      test_wait_timeout();
      test_nmi();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
